// File: rtl/fifo1c_param.sv
// Single-clock parametrised FIFO with show-ahead/normal read, programmable almost thresholds,
// flush and saturating overflow/underflow counters. Define FIFO1C_PARITY_EN for stored parity.
module fifo1c_param #(
    parameter int unsigned DATA_WIDTH = 108,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned SHOWAHEAD  = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   aful_thres,
    input  logic [ADDR_WIDTH:0]   aemp_thres,
    input  logic                  stat_clr,
    input  logic                  par_inject,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic [ADDR_WIDTH:0]   highest_dw,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CNT_WIDTH-1:0]  ovf_cnt,
    output logic [CNT_WIDTH-1:0]  unf_cnt,
    output logic                  parity_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
`ifdef FIFO1C_PARITY_EN
    localparam int unsigned MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int unsigned MEM_WIDTH = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH:0]   FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   LVL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [MEM_WIDTH-1:0]  mem [DEPTH];
    logic [MEM_WIDTH-1:0]  wr_word, rd_word;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   usedw_q, usedw_d, highest_q, highest_d;
    logic                  empty_q, full_q, afull_q, aempty_q;
    logic                  ovf_q, unf_q, ovf_d, unf_d;
    logic [CNT_WIDTH-1:0]  ovf_cnt_q, ovf_cnt_d, unf_cnt_q, unf_cnt_d;
    logic                  rd_accept, wr_accept;

    // Flush masks all traffic, including the overflow/underflow events it would cause.
    assign rd_accept = rdreq & ~empty_q & ~flush;
    assign wr_accept = wrreq & (~full_q | rd_accept) & ~flush;
    assign ovf_d     = wrreq & full_q & ~rd_accept & ~flush;
    assign unf_d     = rdreq & empty_q & ~flush;

`ifdef FIFO1C_PARITY_EN
    assign wr_word = {(^data) ^ par_inject, data};
`else
    assign wr_word = data;
`endif
    assign rd_word = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_word;
        end
    end

    always_comb begin
        usedw_d = usedw_q;
        if (flush) begin
            usedw_d = '0;
        end else if (wr_accept && !rd_accept) begin
            usedw_d = usedw_q + LVL_ONE;
        end else if (rd_accept && !wr_accept) begin
            usedw_d = usedw_q - LVL_ONE;
        end

        highest_d = (usedw_d > highest_q) ? usedw_d : highest_q;
        ovf_cnt_d = ovf_cnt_q;
        unf_cnt_d = unf_cnt_q;
        if (stat_clr) begin
            highest_d = usedw_d;
            ovf_cnt_d = '0;
            unf_cnt_d = '0;
        end else begin
            if (ovf_d && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + CNT_ONE;
            if (unf_d && unf_cnt_q != '1) unf_cnt_d = unf_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            usedw_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            highest_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_accept) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (rd_accept) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            usedw_q   <= usedw_d;
            empty_q   <= (usedw_d == '0);
            full_q    <= (usedw_d == FULL_LVL);
            afull_q   <= (usedw_d >= aful_thres);
            aempty_q  <= (usedw_d <= aemp_thres);
            highest_q <= highest_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            ovf_cnt_q <= ovf_cnt_d;
            unf_cnt_q <= unf_cnt_d;
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            assign q = empty_q ? '0 : rd_word[DATA_WIDTH-1:0];
        end else begin : g_normal
            logic [DATA_WIDTH-1:0] q_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_q <= '0;
                end else if (rd_accept) begin
                    q_q <= rd_word[DATA_WIDTH-1:0];
                end
            end
            assign q = q_q;
        end
    endgenerate

`ifdef FIFO1C_PARITY_EN
    logic parity_err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= rd_accept & (^rd_word);
        end
    end
    assign parity_err = parity_err_q;
`else
    logic unused_par;
    assign unused_par = par_inject;
    assign parity_err = 1'b0;
`endif

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign usedw        = usedw_q;
    assign highest_dw   = highest_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign ovf_cnt      = ovf_cnt_q;
    assign unf_cnt      = unf_cnt_q;

endmodule

// File: tb/tb_fifo1c_param.sv
// Directed bench for fifo1c_param: show-ahead instance driven against a data scoreboard queue,
// plus a normal-mode instance. Parity expectations follow FIFO1C_PARITY_EN.
module tb_fifo1c_param;

    localparam int unsigned DW = 108;
    localparam int unsigned AW = 4;
    localparam int unsigned CW = 16;
`ifdef FIFO1C_PARITY_EN
    localparam logic PAR_EXP = 1'b1;
`else
    localparam logic PAR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data = '0, b_data = '0;
    logic          wrreq = 0, rdreq = 0, b_wrreq = 0, b_rdreq = 0;
    logic          flush = 0, stat_clr = 0, par_inject = 0;
    logic [AW:0]   aful_thres = 5'd16, aemp_thres = 5'd0;

    logic [DW-1:0] q, b_q;
    logic          empty, full, almost_full, almost_empty, overflow, underflow, parity_err;
    logic [AW:0]   usedw, highest_dw;
    logic [CW-1:0] ovf_cnt, unf_cnt;
    logic          b_empty, b_full, b_af, b_ae, b_ovf, b_unf, b_perr;
    logic [AW:0]   b_usedw, b_highest;
    logic [CW-1:0] b_ovf_cnt, b_unf_cnt;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] sb[$];

    always #5 clk = ~clk;

    fifo1c_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHOWAHEAD(1), .CNT_WIDTH(CW)) dut_a (
        .clk(clk), .rst(rst), .data(data), .wrreq(wrreq), .rdreq(rdreq), .flush(flush),
        .aful_thres(aful_thres), .aemp_thres(aemp_thres), .stat_clr(stat_clr),
        .par_inject(par_inject), .q(q), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty), .usedw(usedw),
        .highest_dw(highest_dw), .overflow(overflow), .underflow(underflow),
        .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt), .parity_err(parity_err)
    );

    fifo1c_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHOWAHEAD(0), .CNT_WIDTH(CW)) dut_b (
        .clk(clk), .rst(rst), .data(b_data), .wrreq(b_wrreq), .rdreq(b_rdreq), .flush(1'b0),
        .aful_thres(aful_thres), .aemp_thres(aemp_thres), .stat_clr(1'b0),
        .par_inject(1'b0), .q(b_q), .empty(b_empty), .full(b_full),
        .almost_full(b_af), .almost_empty(b_ae), .usedw(b_usedw),
        .highest_dw(b_highest), .overflow(b_ovf), .underflow(b_unf),
        .ovf_cnt(b_ovf_cnt), .unf_cnt(b_unf_cnt), .parity_err(b_perr)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_d;

        // Reset state
        tick();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
        chk("rst_usedw", usedw, 0);
        chk("rst_q", q, 0);
        chk("rst_highest", highest_dw, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        chk("rst_unf_cnt", unf_cnt, 0);
        chk("rst_pulses", {overflow, underflow, parity_err}, 0);
        chk("rst_b_q", b_q, 0);
        rst = 1'b0;
        tick();

        // Normal-mode instance: q registered after rdreq and held otherwise
        b_wrreq = 1; b_data = 108'hA5; tick();
        b_data = 108'h5A; tick();
        b_wrreq = 0;
        chk("b_q_before_read", b_q, 0);
        b_rdreq = 1; tick();
        b_rdreq = 0;
        chk("b_q_after_read", b_q, 108'hA5);
        tick(); tick();
        chk("b_q_hold", b_q, 108'hA5);
        chk("b_usedw", b_usedw, 1);
        b_rdreq = 1; tick();
        b_rdreq = 0;
        chk("b_q_second", b_q, 108'h5A);
        chk("b_empty", b_empty, 1);

        // Fill 16 words
        for (int i = 1; i <= 16; i++) begin
            wrreq = 1; data = DW'(i); tick();
            sb.push_back(DW'(i));
            if (i == 1) begin
                chk("first_word_visible", q, 1);
                chk("first_not_empty", empty, 0);
            end
            if (i == 15) chk("full_at_15", full, 0);
        end
        chk("full_at_16", full, 1);
        chk("usedw_16", usedw, 16);
        data = 108'h11; tick();
        wrreq = 0;
        chk("overflow_pulse", overflow, 1);
        chk("ovf_cnt_1", ovf_cnt, 1);
        chk("usedw_after_ovf", usedw, 16);
        tick();
        chk("overflow_clear", overflow, 0);

        // Drain in order
        rdreq = 1;
        while (sb.size() > 0) begin
            exp_d = sb.pop_front();
            chk("drain_q", q, exp_d);
            tick();
        end
        rdreq = 0;
        chk("drained_empty", empty, 1);
        chk("drained_usedw", usedw, 0);
        chk("highest_16", highest_dw, 16);

        rdreq = 1; tick();
        rdreq = 0;
        chk("underflow_pulse", underflow, 1);
        chk("unf_cnt_1", unf_cnt, 1);

        // Full with simultaneous write+read across pointer wrap
        wrreq = 1;
        for (int i = 0; i < 16; i++) begin
            data = DW'(32'h100 + i); tick();
            sb.push_back(data);
        end
        rdreq = 1;
        for (int i = 0; i < 20; i++) begin
            exp_d = sb.pop_front();
            chk("wrap_q", q, exp_d);
            data = DW'(32'h200 + i); tick();
            sb.push_back(data);
            chk("wrap_usedw", usedw, 16);
            chk("wrap_no_ovf", overflow, 0);
        end
        wrreq = 0;
        while (sb.size() > 0) begin
            exp_d = sb.pop_front();
            chk("wrap_drain_q", q, exp_d);
            tick();
        end
        rdreq = 0;
        chk("wrap_ovf_cnt", ovf_cnt, 1);

        // Programmable thresholds
        aful_thres = 5'd12; aemp_thres = 5'd3; tick();
        chk("thr_ae_idle", almost_empty, 1);
        chk("thr_af_idle", almost_full, 0);
        wrreq = 1;
        for (int i = 1; i <= 12; i++) begin
            data = DW'(32'h300 + i); tick();
            sb.push_back(data);
            if (i == 3) chk("ae_at_3", almost_empty, 1);
            if (i == 4) chk("ae_at_4", almost_empty, 0);
            if (i == 11) chk("af_at_11", almost_full, 0);
        end
        wrreq = 0;
        chk("af_at_12", almost_full, 1);
        chk("usedw_12", usedw, 12);
        rdreq = 1;
        for (int i = 0; i < 2; i++) begin
            exp_d = sb.pop_front();
            chk("thr_q", q, exp_d);
            tick();
        end
        rdreq = 0;
        chk("af_at_10", almost_full, 0);
        aful_thres = 5'd8; tick();
        chk("af_thres_change", almost_full, 1);
        rdreq = 1;
        while (sb.size() > 0) begin
            exp_d = sb.pop_front();
            chk("thr_drain_q", q, exp_d);
            tick();
            if (sb.size() == 4) chk("ae_drain_4", almost_empty, 0);
            if (sb.size() == 3) chk("ae_drain_3", almost_empty, 1);
        end
        rdreq = 0;
        aful_thres = 5'd16; aemp_thres = 5'd0;

        // Statistics clear, then flush with concurrent traffic
        stat_clr = 1; tick();
        stat_clr = 0;
        chk("clr_highest", highest_dw, 0);
        chk("clr_ovf_cnt", ovf_cnt, 0);
        chk("clr_unf_cnt", unf_cnt, 0);
        wrreq = 1;
        for (int i = 1; i <= 9; i++) begin
            data = DW'(32'h400 + i); tick();
            sb.push_back(data);
        end
        chk("highest_9", highest_dw, 9);
        flush = 1; rdreq = 1; data = 108'h4FF; tick();
        flush = 0; rdreq = 0; wrreq = 0;
        sb.delete();
        chk("flush_usedw", usedw, 0);
        chk("flush_empty", empty, 1);
        chk("flush_pulses", {overflow, underflow}, 0);
        chk("flush_highest", highest_dw, 9);
        stat_clr = 1; tick();
        stat_clr = 0;
        chk("clr_highest_after_flush", highest_dw, 0);

        // Empty with simultaneous write and read: write taken, read underflows
        wrreq = 1; rdreq = 1; data = 108'hABC; tick();
        wrreq = 0; rdreq = 0;
        sb.push_back(108'hABC);
        chk("empty_wr_rd_usedw", usedw, 1);
        chk("empty_wr_rd_unf", underflow, 1);
        chk("empty_wr_rd_cnt", unf_cnt, 1);
        rdreq = 1;
        exp_d = sb.pop_front();
        chk("empty_wr_rd_q", q, exp_d);
        tick();
        rdreq = 0;
        chk("empty_wr_rd_done", empty, 1);

        // Parity injection and clean word
        wrreq = 1; par_inject = 1; data = 108'h1234; tick();
        par_inject = 0; data = 108'h77; tick();
        wrreq = 0;
        sb.push_back(108'h1234);
        sb.push_back(108'h77);
        rdreq = 1;
        exp_d = sb.pop_front();
        chk("par_q", q, exp_d);
        tick();
        chk("parity_err_pulse", parity_err, PAR_EXP);
        exp_d = sb.pop_front();
        chk("par_q2", q, exp_d);
        tick();
        rdreq = 0;
        chk("parity_clean", parity_err, 0);

        // Three underflows after clearing counters
        stat_clr = 1; tick();
        stat_clr = 0;
        rdreq = 1;
        for (int i = 0; i < 3; i++) tick();
        rdreq = 0;
        chk("unf_cnt_3", unf_cnt, 3);
        chk("unf_no_ovf", ovf_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
